// File: rtl/mem_arbiter_if.sv
// Bundle of requester-side and downstream-bus signals for the memory arbiter.
// Combinational wiring only; no latency of its own.
// Handshake is req/addr_ok then data_ok; the arbiter holds the bus until addr_ok.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32
);
  // Instruction requester (read-only, word sized)
  logic              inst_req;
  logic [ADDR_W-1:0] inst_addr;
  logic              inst_addr_ok;
  logic              inst_data_ok;
  logic [31:0]       inst_rdata;

  // Data requester (loads and stores)
  logic              data_req;
  logic              data_wr;
  logic [1:0]        data_size;
  logic [ADDR_W-1:0] data_addr;
  logic [31:0]       data_wdata;
  logic              data_addr_ok;
  logic              data_data_ok;
  logic [31:0]       data_rdata;

  // Shared downstream bus
  logic              m_req;
  logic              m_wr;
  logic [1:0]        m_size;
  logic [ADDR_W-1:0] m_addr;
  logic [31:0]       m_wdata;
  logic              m_addr_ok;
  logic              m_data_ok;
  logic [31:0]       m_rdata;

  logic              busy;

  // Arbiter view: serves both requesters and masters the downstream bus.
  modport master (
    input  inst_req, inst_addr,
    output inst_addr_ok, inst_data_ok, inst_rdata,
    input  data_req, data_wr, data_size, data_addr, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata,
    output m_req, m_wr, m_size, m_addr, m_wdata,
    input  m_addr_ok, m_data_ok, m_rdata,
    output busy
  );

  // Environment view: the two requesters plus the downstream memory slave.
  modport slave (
    output inst_req, inst_addr,
    input  inst_addr_ok, inst_data_ok, inst_rdata,
    output data_req, data_wr, data_size, data_addr, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata,
    input  m_req, m_wr, m_size, m_addr, m_wdata,
    output m_addr_ok, m_data_ok, m_rdata,
    input  busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter (data over instruction) onto one in-order bus.
// Request seen in IDLE at T drives m_req at T+1; zero-wait slave gives data_ok at T+2.
// Only one transaction outstanding; requests wait until the bus returns to IDLE.
module mem_arbiter #(
  parameter int ADDR_W = 32
) (
  input logic         clk,
  input logic         rst,
  mem_arbiter_if.master bus
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
  typedef enum logic {OWN_INST, OWN_DATA} owner_t;

  state_t            state;
  owner_t            owner;
  logic              regWr;
  logic [1:0]        regSize;
  logic [ADDR_W-1:0] regAddr;
  logic [31:0]       regWdata;

  logic inAddr;
  logic inData;
  logic addrHs;
  logic dataHs;

  // Grant in IDLE (data first), capture the winner's request, then walk the address and data phases.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      owner    <= OWN_INST;
      regWr    <= 1'b0;
      regSize  <= 2'd0;
      regAddr  <= '0;
      regWdata <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.data_req) begin
            owner    <= OWN_DATA;
            regWr    <= bus.data_wr;
            regSize  <= bus.data_size;
            regAddr  <= bus.data_addr;
            regWdata <= bus.data_wdata;
            state    <= ADDR;
          end else if (bus.inst_req) begin
            // Fetches are always word reads with no store data.
            owner    <= OWN_INST;
            regWr    <= 1'b0;
            regSize  <= 2'd2;
            regAddr  <= bus.inst_addr;
            regWdata <= 32'd0;
            state    <= ADDR;
          end
        end
        ADDR: if (bus.m_addr_ok) state <= DATA;
        DATA: if (bus.m_data_ok) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Bus and response outputs; everything is forced quiet while reset is held.
  always_comb begin
    inAddr = rst && (state == ADDR);
    inData = rst && (state == DATA);
    addrHs = inAddr && bus.m_addr_ok;
    dataHs = inData && bus.m_data_ok;

    bus.m_req   = inAddr;
    bus.m_wr    = inAddr && regWr;
    bus.m_size  = inAddr ? regSize  : 2'd0;
    bus.m_addr  = inAddr ? regAddr  : '0;
    bus.m_wdata = inAddr ? regWdata : 32'd0;

    bus.inst_addr_ok = addrHs && (owner == OWN_INST);
    bus.data_addr_ok = addrHs && (owner == OWN_DATA);
    bus.inst_data_ok = dataHs && (owner == OWN_INST);
    bus.data_data_ok = dataHs && (owner == OWN_DATA);
    bus.inst_rdata   = (dataHs && (owner == OWN_INST)) ? bus.m_rdata : 32'd0;
    bus.data_rdata   = (dataHs && (owner == OWN_DATA)) ? bus.m_rdata : 32'd0;

    bus.busy = rst && (state != IDLE);
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios then randomized traffic.
// Every cycle is compared against a transaction-level model of the arbiter.
// The bench plays both requesters and a memory slave with random stalls.
module tb_mem_arbiter;
  localparam int ADDR_W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(ADDR_W)) bus ();
  mem_arbiter #(.ADDR_W(ADDR_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  // Transaction-level reference: the one transaction in flight, if any.
  bit          txnLive, txnAccepted, txnIsData;
  logic        txnWr;
  logic [1:0]  txnSize;
  logic [31:0] txnAddr, txnWdata;

  // Observed event log
  int cyc;
  int evMreq, evIaok, evIdok, evDaok, evDdok;
  int nDaok, nDdok, nIdok;
  logic [31:0] lastIrdata;
  bit sawIaok, sawDaok;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clearEvents();
    evMreq = -1; evIaok = -1; evIdok = -1; evDaok = -1; evDdok = -1;
    nDaok = 0; nDdok = 0; nIdok = 0;
  endtask

  task automatic idleInputs();
    bus.inst_req = 0; bus.inst_addr = 0;
    bus.data_req = 0; bus.data_wr = 0; bus.data_size = 0; bus.data_addr = 0; bus.data_wdata = 0;
    bus.m_addr_ok = 0; bus.m_data_ok = 0; bus.m_rdata = 0;
  endtask

  // One clock cycle: inputs already applied; compare, log, advance the model.
  task automatic step();
    logic expReq, expBusy, expIaok, expDaok, expIdok, expDdok;
    logic [31:0] expIrd, expDrd;
    #1;
    expReq = 0; expBusy = 0; expIaok = 0; expDaok = 0; expIdok = 0; expDdok = 0;
    expIrd = 0; expDrd = 0;
    if (rst && txnLive) begin
      expBusy = 1;
      if (!txnAccepted) begin
        expReq = 1;
        if (txnIsData) expDaok = bus.m_addr_ok; else expIaok = bus.m_addr_ok;
      end else if (bus.m_data_ok) begin
        if (txnIsData) begin expDdok = 1; expDrd = bus.m_rdata; end
        else begin expIdok = 1; expIrd = bus.m_rdata; end
      end
    end
    chk("m_req", bus.m_req, expReq);
    chk("busy", bus.busy, expBusy);
    chk("inst_addr_ok", bus.inst_addr_ok, expIaok);
    chk("data_addr_ok", bus.data_addr_ok, expDaok);
    chk("inst_data_ok", bus.inst_data_ok, expIdok);
    chk("data_data_ok", bus.data_data_ok, expDdok);
    chk("inst_rdata", bus.inst_rdata, expIrd);
    chk("data_rdata", bus.data_rdata, expDrd);
    if (expReq) begin
      chk("m_wr", bus.m_wr, txnWr);
      chk("m_size", bus.m_size, txnSize);
      chk("m_addr", bus.m_addr, txnAddr);
      chk("m_wdata", bus.m_wdata, txnWdata);
    end
    sawIaok = bus.inst_addr_ok;
    sawDaok = bus.data_addr_ok;
    if (bus.m_req) evMreq = cyc;
    if (bus.inst_addr_ok) evIaok = cyc;
    if (bus.data_addr_ok) begin evDaok = cyc; nDaok++; end
    if (bus.inst_data_ok) begin evIdok = cyc; nIdok++; lastIrdata = bus.inst_rdata; end
    if (bus.data_data_ok) begin evDdok = cyc; nDdok++; end
    // Model advance at the coming rising edge
    if (!rst) begin
      txnLive = 0; txnAccepted = 0;
    end else if (!txnLive) begin
      if (bus.data_req) begin
        txnLive = 1; txnAccepted = 0; txnIsData = 1;
        txnWr = bus.data_wr; txnSize = bus.data_size;
        txnAddr = bus.data_addr; txnWdata = bus.data_wdata;
      end else if (bus.inst_req) begin
        txnLive = 1; txnAccepted = 0; txnIsData = 0;
        txnWr = 0; txnSize = 2; txnAddr = bus.inst_addr; txnWdata = 0;
      end
    end else if (!txnAccepted) begin
      if (bus.m_addr_ok) txnAccepted = 1;
    end else if (bus.m_data_ok) begin
      txnLive = 0;
    end
    @(negedge clk);
    cyc++;
  endtask

  initial begin
    int t;
    cyc = 0; txnLive = 0; txnAccepted = 0; txnIsData = 0;
    txnWr = 0; txnSize = 0; txnAddr = 0; txnWdata = 0;
    lastIrdata = 0; sawIaok = 0; sawDaok = 0;
    clearEvents();
    rst = 0;
    idleInputs();
    @(negedge clk);
    step(); step();
    chk("reset_busy", bus.busy, 1'b0);
    rst = 1;
    step();

    // Single zero-wait instruction fetch
    clearEvents();
    bus.inst_req = 1; bus.inst_addr = 32'hBFC00000;
    t = cyc; step();
    bus.m_addr_ok = 1; step();
    bus.inst_req = 0; bus.m_addr_ok = 0; bus.m_data_ok = 1; bus.m_rdata = 32'h3C080001; step();
    bus.m_data_ok = 0; step();
    chk("fetch_mreq_cyc", evMreq, t + 1);
    chk("fetch_addr_ok_cyc", evIaok, t + 1);
    chk("fetch_data_ok_cyc", evIdok, t + 2);
    chk("fetch_rdata", lastIrdata, 32'h3C080001);

    // Simultaneous requests: data write wins, fetch follows without a bubble
    clearEvents();
    bus.inst_req = 1; bus.inst_addr = 32'hBFC00004;
    bus.data_req = 1; bus.data_wr = 1; bus.data_size = 2;
    bus.data_addr = 32'h80001000; bus.data_wdata = 32'hDEADBEEF;
    t = cyc; step();
    chk("prio_m_wr", bus.m_wr, 1'b1);
    bus.m_addr_ok = 1; step();
    bus.data_req = 0; bus.m_addr_ok = 0; bus.m_data_ok = 1; bus.m_rdata = 32'h0; step();
    bus.m_data_ok = 0; step();
    bus.m_addr_ok = 1; step();
    bus.inst_req = 0; bus.m_addr_ok = 0; bus.m_data_ok = 1; bus.m_rdata = 32'h11112222; step();
    bus.m_data_ok = 0; step();
    chk("prio_data_addr_ok_cyc", evDaok, t + 1);
    chk("prio_data_ok_cyc", evDdok, t + 2);
    chk("prio_inst_addr_ok_cyc", evIaok, t + 4);
    chk("prio_inst_mreq_last", evMreq, t + 4);

    // Address stall with requester changing its inputs meanwhile
    clearEvents();
    bus.data_req = 1; bus.data_wr = 1; bus.data_size = 2;
    bus.data_addr = 32'h80002000; bus.data_wdata = 32'h12345678;
    step();
    for (int i = 0; i < 3; i++) begin
      bus.data_addr = $urandom; bus.data_wdata = $urandom; bus.data_size = 2'($urandom_range(0, 2));
      step();
      chk("stall_m_addr", bus.m_addr, 32'h80002000);
    end
    bus.m_addr_ok = 1; step();
    bus.data_req = 0; bus.m_addr_ok = 0; bus.m_data_ok = 1; step();
    bus.m_data_ok = 0; step();
    chk("stall_addr_ok_pulses", nDaok, 1);

    // Byte store at an odd address passes through unmodified
    bus.data_req = 1; bus.data_wr = 1; bus.data_size = 0;
    bus.data_addr = 32'h80000003; bus.data_wdata = 32'h000000AB;
    step();
    chk("byte_m_size", bus.m_size, 2'd0);
    chk("byte_m_addr", bus.m_addr, 32'h80000003);
    bus.m_addr_ok = 1; step();
    bus.data_req = 0; bus.m_addr_ok = 0; bus.m_data_ok = 1; step();
    bus.m_data_ok = 0; step();

    // Reset during the data phase, late m_data_ok afterwards
    clearEvents();
    bus.data_req = 1; bus.data_wr = 0; bus.data_size = 2; bus.data_addr = 32'h80003000;
    step();
    bus.m_addr_ok = 1; step();
    bus.data_req = 0; bus.m_addr_ok = 0; rst = 0; step();
    rst = 1; bus.m_data_ok = 1; bus.m_rdata = 32'hFFFF0000; step();
    chk("rstdata_busy", bus.busy, 1'b0);
    bus.m_data_ok = 0; step();
    chk("rstdata_no_data_ok", nDdok, 0);

    // Spurious m_data_ok in IDLE and in ADDR
    clearEvents();
    bus.m_data_ok = 1; step();
    chk("spur_idle_busy", bus.busy, 1'b0);
    bus.m_data_ok = 0; bus.inst_req = 1; bus.inst_addr = 32'hBFC00100;
    step();
    bus.m_data_ok = 1; step();
    chk("spur_addr_still_mreq", bus.m_req, 1'b1);
    bus.m_data_ok = 0; bus.m_addr_ok = 1; step();
    bus.inst_req = 0; bus.m_addr_ok = 0; bus.m_data_ok = 1; bus.m_rdata = 32'hCAFEF00D; step();
    bus.m_data_ok = 0; step();
    chk("spur_inst_data_ok_count", nIdok, 1);

    // Randomized traffic with stalls, spurious handshakes and occasional reset
    for (int n = 0; n < 600; n++) begin
      if (bus.inst_req) begin
        if (sawIaok) bus.inst_req = 0;
      end else begin
        bus.inst_addr = $urandom & 32'hFFFFFFFC;
        if ($urandom_range(0, 3) == 0) bus.inst_req = 1;
      end
      if (bus.data_req) begin
        if (sawDaok) bus.data_req = 0;
        else if (txnLive && txnIsData) begin
          bus.data_addr = $urandom; bus.data_wdata = $urandom; bus.data_wr = 1'($urandom);
        end
      end else if ($urandom_range(0, 3) == 0) begin
        bus.data_req = 1; bus.data_wr = 1'($urandom); bus.data_size = 2'($urandom_range(0, 2));
        bus.data_addr = $urandom; bus.data_wdata = $urandom;
      end
      bus.m_addr_ok = ($urandom_range(0, 2) == 0);
      bus.m_data_ok = ($urandom_range(0, 2) == 0);
      bus.m_rdata = $urandom;
      rst = ($urandom_range(0, 79) != 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: ADDR_W, 32, width of all address ports.
REQ-002 Port: clk  in  1  single clock; all state changes on its rising edge.
REQ-003 Port: rst  in  1  reset, synchronous, active-low.
REQ-004 Port: inst_req  in  1  instruction-side request; held high until inst_addr_ok.
REQ-005 Port: inst_addr  in  ADDR_W  instruction fetch address (read-only side, size fixed at 2).
REQ-006 Port: inst_addr_ok / inst_data_ok  out  1 / 1  address accepted / read data valid.
REQ-007 Port: inst_rdata  out  32  fetched word.
REQ-008 Port: data_req, data_wr  in  1 / 1  data-side request; write when data_wr=1.
REQ-009 Port: data_size, data_addr, data_wdata  in  2 / ADDR_W / 32  byte-count code (0=1B, 1=2B, 2=4B), address, store data.
REQ-010 Port: data_addr_ok / data_data_ok  out  1 / 1; data_rdata  out  32.
REQ-011 Port: m_req, m_wr, m_size, m_addr, m_wdata  out  1 / 1 / 2 / ADDR_W / 32  shared downstream bus.
REQ-012 Port: m_addr_ok, m_data_ok  in  1 / 1; m_rdata  in  32.
REQ-013 Port: busy  out  1  high whenever the state is not IDLE.

Function
REQ-014 The FSM SHALL have three states: IDLE, ADDR, DATA.
REQ-015 At most one downstream transaction SHALL be outstanding.
REQ-016 IDLE: if data_req=1, owner:=DATA. Else if inst_req=1, owner:=INST. Either case SHALL register the owner's wr/size/addr/wdata and go to ADDR next cycle.
REQ-017 Strict priority: with both requests high in the same IDLE cycle, data SHALL win; inst_req stays pending.
REQ-018 ADDR: m_req=1 and m/wr/size/addr/wdata SHALL come from the registered values, stable until m_addr_ok=1.
REQ-019 ADDR with m_addr_ok=1: the owner's *_addr_ok SHALL pulse high combinationally for exactly that cycle; next state DATA.
REQ-020 DATA: m_req=0. On m_data_ok=1 the owner's *_data_ok SHALL pulse for that cycle, owner *_rdata=m_rdata, and next state SHALL be IDLE.
REQ-021 The non-owner's addr_ok/data_ok SHALL be 0 at all times; the non-owner's rdata SHALL be 0.
REQ-022 m_data_ok outside DATA and m_addr_ok outside ADDR SHALL be ignored.
REQ-023 Latency: request sampled in IDLE at cycle T gives m_req at T+1. With zero-wait slave (m_addr_ok at T+1, m_data_ok at T+2), owner data_ok SHALL occur at T+2, and IDLE is re-entered at T+3.
REQ-024 Back-to-back: a pending request SHALL be sampled in the IDLE cycle directly after DATA completes, with no extra bubble.
REQ-025 Instruction requests SHALL always drive m_wr=0, m_size=2, m_wdata=0.
REQ-026 Changes on requester inputs after capture SHALL NOT affect the bus until the next IDLE.

Reset
REQ-027 While rst=0 at a clock edge: state:=IDLE, owner:=INST, and registered request fields SHALL be 0.
REQ-028 In reset and in IDLE, all outputs SHALL be 0 (m_req, all *_ok, rdata, busy).
REQ-029 Reset asserted in ADDR or DATA SHALL abandon the transaction without any *_ok pulse. A late m_data_ok after reset SHALL be ignored.

Verification
REQ-030 Single inst read at 0xBFC00000, zero-wait slave returning 0x3C080001: m_req at T+1, inst_addr_ok at T+1, inst_data_ok and inst_rdata=0x3C080001 at T+2.
REQ-031 inst_req and data_req (write, size=2, addr 0x80001000, wdata 0xDEADBEEF) both high at T: bus carries the data write first with m_wr=1. The inst read follows, with m_req at T+4. data_addr_ok is never concurrent with inst_addr_ok.
REQ-032 Slave stalls m_addr_ok 3 cycles: m_addr, m_size, m_wdata held constant while the requester changes data_addr. Only one addr_ok pulse.
REQ-033 Byte store, size=0, addr 0x80000003: m_size=0, m_addr=0x80000003 unmodified.
REQ-034 rst=0 during DATA, then m_data_ok=1 one cycle after release: no data_ok pulse, busy=0, state IDLE.
REQ-035 Spurious m_data_ok=1 in IDLE and in ADDR: no *_data_ok output, no state change.
